// File: rtl/phys_reg_free_list.sv
`default_nettype none
// ============================================================================
// Module   : phys_reg_free_list
// Purpose  : Circular FIFO of free physical register addresses, self-refilled
//            with every non-architectural address after reset or init_clear.
// Revision : 1.0 - initial release
// ============================================================================
module phys_reg_free_list #(
  parameter int DEPTH          = 64,
  parameter int ARCH_REGS      = 32,
  parameter bit ALLOW_WRITE_P0 = 1'b0,
  localparam int ENTRIES       = DEPTH - ARCH_REGS,
  localparam int AW            = $clog2(DEPTH),
  localparam int PW            = (ENTRIES > 1) ? $clog2(ENTRIES) : 1,
  localparam int CW            = $clog2(ENTRIES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init_clear,
  output logic          ready,
  output logic          alloc_valid,
  output logic [AW-1:0] alloc_addr,
  input  logic          alloc_pop,
  input  logic          release_valid,
  input  logic [AW-1:0] release_addr,
  output logic [CW-1:0] count
);

  localparam logic [PW-1:0] LAST_IDX = PW'(ENTRIES - 1);
  localparam bit            IS_POW2  = ((ENTRIES & (ENTRIES - 1)) == 0);

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] fill_cnt_q, fill_cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] mem_q [ENTRIES];

  logic          mem_we;
  logic [PW-1:0] mem_waddr;
  logic [AW-1:0] mem_wdata;
  logic [PW-1:0] rd_ptr_inc, wr_ptr_inc, fill_cnt_inc;
  logic          is_run, is_full, is_empty, pop_ok, push_ok;

  generate
    if (IS_POW2) begin : g_pow2_wrap
      assign rd_ptr_inc   = rd_ptr_q + 1'b1;
      assign wr_ptr_inc   = wr_ptr_q + 1'b1;
      assign fill_cnt_inc = fill_cnt_q + 1'b1;
    end else begin : g_explicit_wrap
      assign rd_ptr_inc   = (rd_ptr_q == LAST_IDX)   ? '0 : rd_ptr_q + 1'b1;
      assign wr_ptr_inc   = (wr_ptr_q == LAST_IDX)   ? '0 : wr_ptr_q + 1'b1;
      assign fill_cnt_inc = (fill_cnt_q == LAST_IDX) ? '0 : fill_cnt_q + 1'b1;
    end
  endgenerate

  assign is_run      = (state_q == S_RUN);
  assign is_empty    = (count_q == '0);
  assign is_full     = (count_q == CW'(ENTRIES));
  assign ready       = is_run;
  assign alloc_valid = is_run & ~is_empty;
  assign alloc_addr  = mem_q[rd_ptr_q];
  assign count       = count_q;

  // A push into a full list is only accepted when the head leaves the same cycle.
  assign pop_ok  = alloc_pop & alloc_valid & ~init_clear;
  assign push_ok = is_run & release_valid & ~init_clear & (~is_full | pop_ok);

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fill_cnt_d = fill_cnt_q;
    count_d    = count_q;
    mem_we     = 1'b0;
    mem_waddr  = wr_ptr_q;
    mem_wdata  = release_addr;
    if (init_clear) begin
      state_d    = S_INIT;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fill_cnt_d = '0;
      count_d    = '0;
    end else begin
      case (state_q)
        S_INIT: begin
          mem_we     = 1'b1;
          mem_waddr  = fill_cnt_q;
          mem_wdata  = AW'(ARCH_REGS) + AW'(fill_cnt_q);
          fill_cnt_d = fill_cnt_inc;
          count_d    = count_q + 1'b1;
          if (fill_cnt_q == LAST_IDX) begin
            wr_ptr_d = '0;
            state_d  = S_RUN;
          end
        end
        S_RUN: begin
          if (pop_ok) begin
            rd_ptr_d = rd_ptr_inc;
          end
          if (push_ok) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_inc;
          end
          case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_INIT;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fill_cnt_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      count_q    <= count_d;
    end
  end

  // Storage carries no reset; INIT rewrites every slot before it is read.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst && is_run && !init_clear) begin
      assert (!(release_valid && is_full && !pop_ok))
        else $error("phys_reg_free_list: release into full list dropped");
      assert (!(alloc_pop && !alloc_valid))
        else $error("phys_reg_free_list: pop with no valid entry");
      assert (ALLOW_WRITE_P0 || !(release_valid && release_addr == '0))
        else $error("phys_reg_free_list: physical register 0 released");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_phys_reg_free_list.sv
`default_nettype none
// ============================================================================
// Module   : tb_phys_reg_free_list
// Purpose  : Scoreboard bench for phys_reg_free_list against a queue model of
//            the free set and the mapped set.
// Revision : 1.0 - initial release
// ============================================================================
module tb_phys_reg_free_list;

  localparam int ENT = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       init_clear = 1'b0;
  logic       alloc_pop = 1'b0;
  logic       release_valid = 1'b0;
  logic [5:0] release_addr = '0;
  logic       ready;
  logic       alloc_valid;
  logic [5:0] alloc_addr;
  logic [5:0] count;

  phys_reg_free_list #(.DEPTH(64), .ARCH_REGS(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .init_clear    (init_clear),
    .ready         (ready),
    .alloc_valid   (alloc_valid),
    .alloc_addr    (alloc_addr),
    .alloc_pop     (alloc_pop),
    .release_valid (release_valid),
    .release_addr  (release_addr),
    .count         (count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int model_q[$];   // free addresses in FIFO order
  int mapped[$];    // releasable mapped addresses (0 is kept mapped forever)
  int exp_q[$];     // expected head values for handshakes issued this cycle
  int init_left = ENT;
  int last_pop  = -1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    mapped.delete();
    for (int i = 0; i < ENT; i++) model_q.push_back(32 + i);
    for (int i = 1; i < 32; i++) mapped.push_back(i);
    init_left = ENT;
  endtask

  task automatic take(input int a);
    int idx;
    idx = -1;
    foreach (mapped[i]) if (mapped[i] == a) idx = i;
    if (idx >= 0) mapped.delete(idx);
  endtask

  task automatic take_rand(input int avoid, output int a);
    int idx;
    do begin
      idx = $urandom_range(0, mapped.size() - 1);
    end while (mapped[idx] == avoid);
    a = mapped[idx];
    mapped.delete(idx);
  endtask

  task automatic check_state();
    check("ready", int'(ready), int'(init_left == 0));
    check("count", int'(count), (init_left > 0) ? ENT - init_left : model_q.size());
    check("alloc_valid", int'(alloc_valid), int'(init_left == 0 && model_q.size() != 0));
    check("count_max", int'(count <= 6'd32), 1);
    check("sb_drain", exp_q.size(), 0);
  endtask

  // Inputs applied now, consumed on the next rising edge; outputs checked 1ns after it.
  task automatic drive(input bit pop, input bit push, input int addr, input bit clr);
    int v;
    alloc_pop     = pop;
    release_valid = push;
    release_addr  = 6'(addr);
    init_clear    = clr;
    if (clr) begin
      model_reset();
    end else if (init_left > 0) begin
      init_left--;
    end else begin
      if (pop) begin
        v = model_q.pop_front();
        exp_q.push_back(v);
      end
      if (push) model_q.push_back(addr);
      if (pop) mapped.push_back(v);
    end
    @(posedge clk);
    #1;
    alloc_pop     = 1'b0;
    release_valid = 1'b0;
    init_clear    = 1'b0;
    check_state();
  endtask

  task automatic do_reset();
    alloc_pop     = 1'b0;
    release_valid = 1'b0;
    init_clear    = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_async_ready", int'(ready), 0);
    check("rst_async_count", int'(count), 0);
    @(posedge clk);
    #1;
    check("rst_ready", int'(ready), 0);
    check("rst_count", int'(count), 0);
    check("rst_alloc_valid", int'(alloc_valid), 0);
    model_reset();
    rst = 1'b1;
  endtask

  // Monitor: every accepted pop must present the head the model predicted.
  always @(negedge clk) begin
    if (rst && alloc_valid && alloc_pop && !init_clear) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", int'(alloc_addr), -1);
      end else begin
        check("alloc_addr", int'(alloc_addr), exp_q.pop_front());
      end
      last_pop = int'(alloc_addr);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    bit p, q;

    // Reset and initial refill
    do_reset();
    repeat (ENT) drive(1'b0, 1'b0, 0, 1'b0);
    check("init_head", int'(alloc_addr), 32);
    check("init_count", int'(count), 32);

    // Drain back-to-back: 32..63 in order
    repeat (ENT) drive(1'b1, 1'b0, 0, 1'b0);
    check("drain_count", int'(count), 0);

    // Push into empty: not bypassed, visible next cycle
    take(5);
    check("empty_valid_before", int'(alloc_valid), 0);
    drive(1'b0, 1'b1, 5, 1'b0);
    check("empty_push_head", int'(alloc_addr), 5);
    check("empty_push_count", int'(count), 1);

    // Fill to full, then push+pop together while full
    repeat (ENT - 1) begin
      take_rand(7, a);
      drive(1'b0, 1'b1, a, 1'b0);
    end
    check("full_count", int'(count), 32);
    take(7);
    drive(1'b1, 1'b1, 7, 1'b0);
    check("full_pushpop_count", int'(count), 32);
    repeat (ENT) drive(1'b1, 1'b0, 0, 1'b0);
    check("wrap_last", last_pop, 7);

    // init_clear with a concurrent pop
    repeat (10) begin
      take_rand(-1, a);
      drive(1'b0, 1'b1, a, 1'b0);
    end
    check("pre_clear_count", int'(count), 10);
    drive(1'b1, 1'b0, 0, 1'b1);
    repeat (ENT) drive(1'b0, 1'b0, 0, 1'b0);
    check("clear_head", int'(alloc_addr), 32);
    check("clear_count", int'(count), 32);

    // Randomised traffic with a clear and a reset landing mid-INIT
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (cyc == 3000) begin
        drive(1'b0, 1'b0, 0, 1'b1);
      end else if (cyc == 3010) begin
        do_reset();
      end else if (init_left > 0) begin
        drive(1'($urandom % 2), 1'($urandom % 2), $urandom_range(1, 63), 1'b0);
      end else begin
        p = (model_q.size() != 0) && ($urandom % 2 == 1);
        q = (mapped.size() != 0) && ($urandom % 2 == 1) && (model_q.size() < ENT || p);
        a = 0;
        if (q) take_rand(-1, a);
        drive(p, q, a, 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
